// File: rtl/spi_ram_cmd_arbiter.sv
// Round-robin, transaction-locked arbiter for the shared RAM command port.
// Define SPI_ARB_LOCK_TIMEOUT_EN to abandon locks left idle for TIMEOUT_CYCLES.
module spi_ram_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [9:0] req0_din,
   output logic       req0_ready,
   output logic [7:0] req0_dout,
   output logic       req0_dout_valid,
   input  logic       req1_valid,
   input  logic [9:0] req1_din,
   output logic       req1_ready,
   output logic [7:0] req1_dout,
   output logic       req1_dout_valid,
   output logic       ram_rx_valid,
   output logic [9:0] ram_din,
   input  logic [7:0] ram_dout,
   input  logic       ram_tx_valid,
   output logic [1:0] grant,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_LOCK,
      S_RD_LOCK,
      S_RD_WAIT
   } state_t;

   localparam logic [1:0] OP_WA = 2'b00;
   localparam logic [1:0] OP_WD = 2'b01;
   localparam logic [1:0] OP_RA = 2'b10;
   localparam logic [1:0] OP_RF = 2'b11;

   if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       err_q, err_d;
   logic [7:0] dout0_q, dout0_d;
   logic [7:0] dout1_q, dout1_d;
   logic       dv0_q, dv0_d;
   logic       dv1_q, dv1_d;
   logic       sel, act, cur_valid, xfer, fwd, timeout;
   logic [9:0] cur_din;
   logic [1:0] op;

   // In IDLE the selected requester comes from arbitration, else it is the owner.
   always_comb begin
      sel = owner_q;
      if (state_q == S_IDLE) begin
         if (req0_valid && req1_valid) sel = ~last_q;
         else                          sel = req1_valid;
      end
   end

   assign cur_valid  = sel ? req1_valid : req0_valid;
   assign cur_din    = sel ? req1_din : req0_din;
   assign op         = cur_din[9:8];
   assign act        = (state_q == S_IDLE) ? cur_valid :
                       (state_q == S_WR_LOCK || state_q == S_RD_LOCK);
   assign xfer       = act & cur_valid;
   assign req0_ready = act & ~sel;
   assign req1_ready = act & sel;

`ifdef SPI_ARB_LOCK_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q == S_IDLE || xfer) cnt_d = '0;
   end

   assign timeout = (state_q != S_IDLE) && !xfer &&
                    !(state_q == S_RD_WAIT && ram_tx_valid) &&
                    (cnt_d == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= timeout ? '0 : cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = 1'b0;
      dout0_d = dout0_q;
      dout1_d = dout1_q;
      dv0_d   = 1'b0;
      dv1_d   = 1'b0;
      fwd     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               owner_d = sel;
               if (op == OP_WA) begin
                  fwd     = 1'b1;
                  state_d = S_WR_LOCK;
               end else if (op == OP_RA) begin
                  fwd     = 1'b1;
                  state_d = S_RD_LOCK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WR_LOCK: begin
            if (xfer) begin
               if (op == OP_WD) begin
                  fwd     = 1'b1;
                  last_d  = owner_q;
                  state_d = S_IDLE;
               end else if (op == OP_WA) begin
                  fwd = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RD_LOCK: begin
            if (xfer) begin
               if (op == OP_RF) begin
                  fwd     = 1'b1;
                  state_d = S_RD_WAIT;
               end else if (op == OP_RA) begin
                  fwd = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RD_WAIT: begin
            if (ram_tx_valid) begin
               if (owner_q) begin
                  dout1_d = ram_dout;
                  dv1_d   = 1'b1;
               end else begin
                  dout0_d = ram_dout;
                  dv0_d   = 1'b1;
               end
               last_d  = owner_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (timeout) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         last_d  = owner_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         dout0_q <= 8'h00;
         dout1_q <= 8'h00;
         dv0_q   <= 1'b0;
         dv1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         err_q   <= err_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
         dv0_q   <= dv0_d;
         dv1_q   <= dv1_d;
      end
   end

   // Zero din when idle so the RAM never sees a stray fetch opcode.
   assign ram_rx_valid    = fwd;
   assign ram_din         = fwd ? cur_din : 10'h000;
   assign grant           = (state_q == S_IDLE) ? 2'b00 :
                            (owner_q ? 2'b10 : 2'b01);
   assign busy            = (state_q != S_IDLE);
   assign err             = err_q;
   assign req0_dout       = dout0_q;
   assign req1_dout       = dout1_q;
   assign req0_dout_valid = dv0_q;
   assign req1_dout_valid = dv1_q;

endmodule

// File: tb/tb_spi_ram_cmd_arbiter.sv
// Directed bench for spi_ram_cmd_arbiter: vector table plus reset,
// arbitration and lock-timeout sequences.
module tb_spi_ram_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [9:0] req0_din, req1_din;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_dout, req1_dout;
   logic       req0_dout_valid, req1_dout_valid;
   logic       ram_rx_valid;
   logic [9:0] ram_din;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;
   logic [1:0] grant;
   logic       busy, err;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spi_ram_cmd_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_din(req0_din),
      .req0_ready(req0_ready), .req0_dout(req0_dout),
      .req0_dout_valid(req0_dout_valid),
      .req1_valid(req1_valid), .req1_din(req1_din),
      .req1_ready(req1_ready), .req1_dout(req1_dout),
      .req1_dout_valid(req1_dout_valid),
      .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
      .grant(grant), .busy(busy), .err(err)
   );

   typedef struct {
      logic       v0;
      logic [9:0] d0;
      logic       v1;
      logic [9:0] d1;
      logic       tx;
      logic [7:0] rd;
      logic       r0;
      logic       r1;
      logic       rxv;
      logic [9:0] din;
      logic [1:0] gnt;
      logic       bsy;
      logic       er;
      logic       dv0;
      logic       dv1;
      logic [7:0] o0;
      logic [7:0] o1;
   } vec_t;

   vec_t tv[26];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v0, input logic [9:0] d0,
                      input logic v1, input logic [9:0] d1,
                      input logic tx, input logic [7:0] rd);
      @(negedge clk);
      req0_valid   = v0;
      req0_din     = d0;
      req1_valid   = v1;
      req1_din     = d1;
      ram_tx_valid = tx;
      ram_dout     = rd;
      #1;
   endtask

   initial begin
      // v0 d0 v1 d1 tx rd | r0 r1 rxv din gnt bsy er dv0 dv1 o0 o1
      tv[0]  = '{1, 10'h012, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h012, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00};
      tv[1]  = '{1, 10'h1A5, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h1A5, 2'b01, 1, 0, 0, 0, 8'h00, 8'h00};
      tv[2]  = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00};
      tv[3]  = '{1, 10'h212, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h212, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00};
      tv[4]  = '{1, 10'h300, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h300, 2'b01, 1, 0, 0, 0, 8'h00, 8'h00};
      tv[5]  = '{0, 10'h000, 0, 10'h000, 1, 8'hA5, 0, 0, 0, 10'h000, 2'b01, 1, 0, 0, 0, 8'h00, 8'h00};
      tv[6]  = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 0, 1, 0, 8'hA5, 8'h00};
      tv[7]  = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[8]  = '{0, 10'h000, 1, 10'h3FF, 0, 8'h00, 0, 1, 0, 10'h000, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[9]  = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 1, 0, 0, 8'hA5, 8'h00};
      tv[10] = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[11] = '{1, 10'h011, 1, 10'h022, 0, 8'h00, 0, 1, 1, 10'h022, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[12] = '{1, 10'h011, 1, 10'h2AA, 0, 8'h00, 0, 1, 0, 10'h000, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[13] = '{1, 10'h011, 1, 10'h033, 0, 8'h00, 0, 1, 1, 10'h033, 2'b10, 1, 1, 0, 0, 8'hA5, 8'h00};
      tv[14] = '{1, 10'h011, 1, 10'h144, 0, 8'h00, 0, 1, 1, 10'h144, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[15] = '{1, 10'h011, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h011, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[16] = '{1, 10'h1BB, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h1BB, 2'b01, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[17] = '{0, 10'h000, 1, 10'h250, 0, 8'h00, 0, 1, 1, 10'h250, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00};
      tv[18] = '{0, 10'h000, 1, 10'h0AA, 0, 8'h00, 0, 1, 0, 10'h000, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[19] = '{0, 10'h000, 1, 10'h251, 0, 8'h00, 0, 1, 1, 10'h251, 2'b10, 1, 1, 0, 0, 8'hA5, 8'h00};
      tv[20] = '{1, 10'h012, 1, 10'h300, 0, 8'h00, 0, 1, 1, 10'h300, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[21] = '{1, 10'h012, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[22] = '{1, 10'h012, 0, 10'h000, 1, 8'h5C, 0, 0, 0, 10'h000, 2'b10, 1, 0, 0, 0, 8'hA5, 8'h00};
      tv[23] = '{1, 10'h012, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h012, 2'b00, 0, 0, 0, 1, 8'hA5, 8'h5C};
      tv[24] = '{1, 10'h100, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h100, 2'b01, 1, 0, 0, 0, 8'hA5, 8'h5C};
      tv[25] = '{0, 10'h000, 0, 10'h000, 0, 8'h00, 0, 0, 0, 10'h000, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h5C};

      rst_n        = 1'b0;
      req0_valid   = 1'b0;
      req0_din     = 10'h000;
      req1_valid   = 1'b0;
      req1_din     = 10'h000;
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.grant", 32'(grant), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.err", 32'(err), 0);
      chk("rst.dout0", 32'(req0_dout), 0);
      chk("rst.dout1", 32'(req1_dout), 0);
      chk("rst.dv", 32'({req0_dout_valid, req1_dout_valid}), 0);
      chk("rst.rxv", 32'(ram_rx_valid), 0);
      chk("rst.din", 32'(ram_din), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         cyc(tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1, tv[i].tx, tv[i].rd);
         chk($sformatf("v%0d.r0", i), 32'(req0_ready), 32'(tv[i].r0));
         chk($sformatf("v%0d.r1", i), 32'(req1_ready), 32'(tv[i].r1));
         chk($sformatf("v%0d.rxv", i), 32'(ram_rx_valid), 32'(tv[i].rxv));
         chk($sformatf("v%0d.din", i), 32'(ram_din), 32'(tv[i].din));
         chk($sformatf("v%0d.gnt", i), 32'(grant), 32'(tv[i].gnt));
         chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tv[i].bsy));
         chk($sformatf("v%0d.err", i), 32'(err), 32'(tv[i].er));
         chk($sformatf("v%0d.dv0", i), 32'(req0_dout_valid), 32'(tv[i].dv0));
         chk($sformatf("v%0d.dv1", i), 32'(req1_dout_valid), 32'(tv[i].dv1));
         chk($sformatf("v%0d.o0", i), 32'(req0_dout), 32'(tv[i].o0));
         chk($sformatf("v%0d.o1", i), 32'(req1_dout), 32'(tv[i].o1));
      end

      // Reset while waiting on read data.
      cyc(1, 10'h277, 0, 10'h000, 0, 8'h00);
      chk("rw.addr", 32'(ram_din), 32'h277);
      cyc(1, 10'h300, 0, 10'h000, 0, 8'h00);
      chk("rw.fetch", 32'(ram_din), 32'h300);
      @(negedge clk);
      rst_n        = 1'b0;
      req0_valid   = 1'b0;
      req0_din     = 10'h000;
      ram_tx_valid = 1'b1;
      ram_dout     = 8'hEE;
      #1;
      chk("rw.grant", 32'(grant), 0);
      chk("rw.busy", 32'(busy), 0);
      chk("rw.dout0", 32'(req0_dout), 0);
      @(negedge clk);
      #1;
      chk("rw.dv0", 32'(req0_dout_valid), 0);
      rst_n        = 1'b1;
      ram_tx_valid = 1'b0;
      cyc(0, 10'h000, 0, 10'h000, 0, 8'h00);
      chk("rw.dv0b", 32'(req0_dout_valid), 0);
      chk("rw.dout0b", 32'(req0_dout), 0);

      // Both valid right after reset: req0 first, req1 stalled.
      cyc(1, 10'h0C1, 1, 10'h0D2, 0, 8'h00);
      chk("b3.r0", 32'(req0_ready), 1);
      chk("b3.r1", 32'(req1_ready), 0);
      chk("b3.din0", 32'(ram_din), 32'h0C1);
      cyc(1, 10'h1C3, 1, 10'h0D2, 0, 8'h00);
      chk("b3.gnt0", 32'(grant), 32'h1);
      chk("b3.stall", 32'(req1_ready), 0);
      chk("b3.din1", 32'(ram_din), 32'h1C3);
      cyc(0, 10'h000, 1, 10'h0D2, 0, 8'h00);
      chk("b3.r1b", 32'(req1_ready), 1);
      chk("b3.din2", 32'(ram_din), 32'h0D2);
      cyc(0, 10'h000, 1, 10'h1D4, 0, 8'h00);
      chk("b3.gnt1", 32'(grant), 32'h2);
      chk("b3.din3", 32'(ram_din), 32'h1D4);

      // Read after reset with T+2 latency.
      cyc(1, 10'h2E0, 0, 10'h000, 0, 8'h00);
      chk("rd.addr", 32'(ram_din), 32'h2E0);
      cyc(1, 10'h300, 0, 10'h000, 0, 8'h00);
      chk("rd.fetch", 32'({ram_rx_valid, ram_din}), 32'h700);
      cyc(0, 10'h000, 0, 10'h000, 1, 8'h3C);
      chk("rd.dv_t1", 32'(req0_dout_valid), 0);
      cyc(0, 10'h000, 0, 10'h000, 0, 8'h00);
      chk("rd.dv_t2", 32'(req0_dout_valid), 1);
      chk("rd.dout", 32'(req0_dout), 32'h3C);
      chk("rd.dv1", 32'(req1_dout_valid), 0);
      cyc(0, 10'h000, 0, 10'h000, 0, 8'h00);
      chk("rd.dv_t3", 32'(req0_dout_valid), 0);

      // req1 opens a write lock and goes silent.
      cyc(0, 10'h000, 1, 10'h005, 0, 8'h00);
      chk("to.r1", 32'(req1_ready), 1);
`ifdef SPI_ARB_LOCK_TIMEOUT_EN
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 10'h0AB, 0, 10'h000, 0, 8'h00);
         chk($sformatf("to.busy%0d", i), 32'(busy), 1);
         chk($sformatf("to.err%0d", i), 32'(err), 0);
      end
      cyc(1, 10'h0AB, 1, 10'h0EE, 0, 8'h00);
      chk("to.err", 32'(err), 1);
      chk("to.idle", 32'(busy), 0);
      chk("to.r0", 32'(req0_ready), 1);
      chk("to.r1b", 32'(req1_ready), 0);
      cyc(1, 10'h1AC, 1, 10'h0EE, 0, 8'h00);
      chk("to.gnt0", 32'(grant), 32'h1);
      chk("to.err2", 32'(err), 0);
      cyc(0, 10'h000, 1, 10'h0EE, 0, 8'h00);
      chk("to.r1c", 32'(req1_ready), 1);
      cyc(0, 10'h000, 1, 10'h1EF, 0, 8'h00);
      chk("to.gnt1", 32'(grant), 32'h2);
`else
      for (int i = 1; i <= 20; i++) begin
         cyc(1, 10'h0AB, 0, 10'h000, 0, 8'h00);
         chk($sformatf("lk.busy%0d", i), 32'(busy), 1);
         chk($sformatf("lk.err%0d", i), 32'(err), 0);
         chk($sformatf("lk.r0_%0d", i), 32'(req0_ready), 0);
      end
      cyc(1, 10'h0AB, 1, 10'h1A5, 0, 8'h00);
      chk("lk.r1", 32'(req1_ready), 1);
      chk("lk.gnt", 32'(grant), 32'h2);
      chk("lk.din", 32'(ram_din), 32'h1A5);
      cyc(1, 10'h0AB, 0, 10'h000, 0, 8'h00);
      chk("lk.r0", 32'(req0_ready), 1);
      chk("lk.idle", 32'(grant), 0);
      cyc(1, 10'h1AC, 0, 10'h000, 0, 8'h00);
      chk("lk.gnt0", 32'(grant), 32'h1);
`endif
      cyc(0, 10'h000, 0, 10'h000, 0, 8'h00);
      chk("end.busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
